// File: rtl/nco_pkg.sv
// Shared constants, types and the quarter-wave sine table generator for the TDM NCO.
package nco_pkg;

  localparam int unsigned NCO_LAT = 4;

  localparam logic CFG_INC = 1'b0;
  localparam logic CFG_OFF = 1'b1;

  typedef logic [1:0] quad_t;

  // round(amp * sin((k+0.5)*pi/2^(raw+1))) in Q30 fixed point, Taylor series to x^15 term
  function automatic int unsigned qsin_val(input int unsigned k, input int unsigned raw,
                                           input int unsigned amp);
    longint x;
    longint x2;
    longint term;
    longint sum;
    x    = longint'(64'(2 * k + 1) * 64'd3373259426 >> (raw + 2));
    x2   = (x * x) / 64'sd1073741824;
    term = x;
    sum  = x;
    for (int n = 1; n <= 7; n++) begin
      term = -((term * x2) / 64'sd1073741824) / longint'(4 * n * n + 2 * n);
      sum  = sum + term;
    end
    return 32'((longint'(amp) * sum + 64'sd536870912) / 64'sd1073741824);
  endfunction

endpackage

// File: rtl/nco_qw_rom.sv
// Synchronous dual-port quarter-wave sine ROM; one port feeds sine, the other cosine.
module nco_qw_rom
  import nco_pkg::*;
#(
  parameter int unsigned RAW  = 10,
  parameter int unsigned DW   = 13,
  parameter              ROMF = "nco_qsin.hex"
) (
  input  logic           clk,
  input  logic           clken,
  input  logic [RAW-1:0] addr_a,
  input  logic [RAW-1:0] addr_b,
  output logic [DW-1:0]  data_a,
  output logic [DW-1:0]  data_b
);

  localparam int unsigned DEPTH = 32'(1) << RAW;
  localparam int unsigned AMP   = (32'(1) << DW) - 32'(1);

  logic [DW-1:0] rom [DEPTH];

  // Table is elaborated in place; ROMF names its hex image, an empty name builds a blank ROM
  if (ROMF != "") begin : g_tbl
    for (genvar k = 0; k < DEPTH; k++) begin : g_word
      localparam logic [DW-1:0] WORD = DW'(qsin_val(32'(k), RAW, AMP));
      assign rom[k] = WORD;
    end
  end else begin : g_blank
    for (genvar k = 0; k < DEPTH; k++) begin : g_word
      assign rom[k] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (clken) begin
      data_a <= rom[addr_a];
      data_b <= rom[addr_b];
    end
  end

endmodule

// File: rtl/nco_tdm_mc.sv
// Time-division multi-channel NCO: per-channel phase state, one shared quarter-wave ROM,
// four-stage pipeline emitting one channel-tagged sin/cos sample per enabled clock.
module nco_tdm_mc
  import nco_pkg::*;
#(
  parameter int unsigned APR  = 32,
  parameter int unsigned MPR  = 14,
  parameter int unsigned NCH  = 4,
  parameter int unsigned CHW  = 2,
  parameter int unsigned RAW  = 10,
  parameter              ROMF = "nco_qsin.hex"
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clken,
  input  logic           cfg_we,
  input  logic           cfg_sel,
  input  logic [CHW-1:0] cfg_chan,
  input  logic [APR-1:0] cfg_data,
  input  logic           acc_clr,
  output logic [MPR-1:0] fsin_o,
  output logic [MPR-1:0] fcos_o,
  output logic [CHW-1:0] out_chan,
  output logic           out_valid
);

  localparam int unsigned AMW   = MPR - 1;
  localparam int unsigned NSLOT = 32'(1) << CHW;
  localparam logic [NSLOT-1:0] CH_OK = NSLOT'((64'(1) << NCH) - 64'(1));

  logic [APR-1:0] inc_r [NCH];
  logic [APR-1:0] off_r [NCH];
  logic [APR-1:0] acc_r [NCH];
  logic [CHW-1:0] slot;

  logic [APR-1:0] ph_c;
  logic           ph_unused;

  logic [RAW+1:0]      ph_s1;
  logic [CHW-1:0]      ch_s1;
  logic [RAW-1:0]      addr_s_s2;
  logic [RAW-1:0]      addr_c_s2;
  logic                neg_s_s2;
  logic                neg_c_s2;
  logic [CHW-1:0]      ch_s2;
  logic                neg_s_s3;
  logic                neg_c_s3;
  logic [CHW-1:0]      ch_s3;
  logic [NCO_LAT-2:0]  vld;
  logic [AMW-1:0]      rom_s;
  logic [AMW-1:0]      rom_c;

  quad_t          q_c;
  logic [RAW-1:0] a_c;

  function automatic logic [MPR-1:0] signed_mag(input logic [AMW-1:0] mag, input logic neg);
    return neg ? MPR'(0) - MPR'(mag) : MPR'(mag);
  endfunction

  // Phase uses the pre-update accumulator; bits below the ROM address are dropped
  assign ph_c      = acc_r[slot] + off_r[slot];
  assign ph_unused = ^ph_c[APR-RAW-3:0];

  // Channel state: config writes and clear run regardless of clken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        inc_r[i] <= '0;
        off_r[i] <= '0;
        acc_r[i] <= '0;
      end
      slot <= '0;
    end else begin
      if (acc_clr) begin
        for (int i = 0; i < NCH; i++) acc_r[i] <= '0;
      end else if (clken) begin
        acc_r[slot] <= acc_r[slot] + inc_r[slot];
      end
      if (cfg_we && CH_OK[cfg_chan]) begin
        if (cfg_sel == CFG_INC) inc_r[cfg_chan] <= cfg_data;
        else                    off_r[cfg_chan] <= cfg_data;
      end
      if (clken) slot <= (slot == CHW'(NCH - 1)) ? '0 : slot + CHW'(1);
    end
  end

  assign q_c = ph_s1[RAW+1 -: 2];
  assign a_c = ph_s1[RAW-1:0];

  // S0..S2 pipeline registers; cosine is the sine mapping shifted by one quadrant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph_s1     <= '0;
      ch_s1     <= '0;
      addr_s_s2 <= '0;
      addr_c_s2 <= '0;
      neg_s_s2  <= 1'b0;
      neg_c_s2  <= 1'b0;
      ch_s2     <= '0;
      neg_s_s3  <= 1'b0;
      neg_c_s3  <= 1'b0;
      ch_s3     <= '0;
      vld       <= '0;
    end else if (clken) begin
      ph_s1     <= ph_c[APR-1 -: RAW+2];
      ch_s1     <= slot;
      addr_s_s2 <= q_c[0] ? ~a_c : a_c;
      addr_c_s2 <= q_c[0] ? a_c : ~a_c;
      neg_s_s2  <= q_c[1];
      neg_c_s2  <= q_c[1] ^ q_c[0];
      ch_s2     <= ch_s1;
      neg_s_s3  <= neg_s_s2;
      neg_c_s3  <= neg_c_s2;
      ch_s3     <= ch_s2;
      vld       <= {vld[NCO_LAT-3:0], 1'b1};
    end
  end

  nco_qw_rom #(
    .RAW  (RAW),
    .DW   (AMW),
    .ROMF (ROMF)
  ) u_rom (
    .clk    (clk),
    .clken  (clken),
    .addr_a (addr_s_s2),
    .addr_b (addr_c_s2),
    .data_a (rom_s),
    .data_b (rom_c)
  );

  // S3: outputs load only on valid samples and hold otherwise; valid is a one-cycle strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsin_o    <= '0;
      fcos_o    <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= clken & vld[NCO_LAT-2];
      if (clken && vld[NCO_LAT-2]) begin
        fsin_o   <= signed_mag(rom_s, neg_s_s3);
        fcos_o   <= signed_mag(rom_c, neg_c_s3);
        out_chan <= ch_s3;
      end
    end
  end

endmodule
